// File: rtl/neuron_pkg.sv
// ============================================================================
// Module      : neuron_pkg
// Description : Shared types and default sizing for the single-neuron
//               sequencer, its term counter and the MAC datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package neuron_pkg;

    // Default sizing shared with the datapath and the selection logic
    localparam int NEURON_N     = 16;
    localparam int NEURON_IDX_W = 16;
    localparam int NEURON_RES_W = 16;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ACCUM  = 3'd2,
        SETTLE = 3'd3,
        VALID  = 3'd4
    } state_t;

endpackage : neuron_pkg

`default_nettype wire

// File: rtl/neuron_controller_term_counter.sv
// ============================================================================
// Module      : term_counter
// Description : Term index counter for the neuron sequencer. Counts 0..N-1
//               while enabled and returns to 0 after the last term, so the
//               count never exceeds N-1. o_last is a registered flag that is
//               high for the cycle following the last enabled term.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module term_counter
    import neuron_pkg::*;
#(
    parameter int IDX_W = NEURON_IDX_W,
    parameter int N     = NEURON_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [IDX_W-1:0] o_count,
    output logic             o_last
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);

    logic [IDX_W-1:0] r_count;
    logic             r_last;
    logic             w_at_end;

    assign w_at_end = (r_count == c_last_idx);

    // Count enabled terms; clear has priority and also suppresses the last flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
            r_last  <= 1'b0;
        end else begin
            r_last <= i_en && !i_clr && w_at_end;
            if (i_clr) begin
                r_count <= '0;
            end else if (i_en) begin
                r_count <= w_at_end ? '0 : r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_last  = r_last;

endmodule : term_counter

`default_nettype wire

// File: rtl/neuron_controller.sv
// ============================================================================
// Module      : neuron_controller
// Description : Sequencer for a single-neuron MAC datapath. Per request it
//               pulses an accumulator clear, steps the term index 0..N-1 with
//               ld asserted, captures the activated result one settle cycle
//               later and offers it downstream on a valid/ready handshake.
//               Optional macro NEURON_CTRL_ABORT_EN adds an i_abort input that
//               cancels an evaluation in CLEAR, ACCUM or SETTLE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_controller
    import neuron_pkg::*;
#(
    parameter int N     = NEURON_N,
    parameter int IDX_W = NEURON_IDX_W,
    parameter int RES_W = NEURON_RES_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
`ifdef NEURON_CTRL_ABORT_EN
    input  logic             i_abort,
`endif
    output logic             o_busy,
    output logic             o_acc_clr,
    output logic             o_ld,
    output logic [IDX_W-1:0] o_index,
    input  logic [RES_W-1:0] i_result_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [RES_W-1:0] o_out_data
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);

    state_t           r_state;
    logic             r_busy;
    logic             r_acc_clr;
    logic             r_ld;
    logic             r_out_valid;
    logic [RES_W-1:0] r_out_data;

    logic [IDX_W-1:0] w_count;
    logic             w_last;
    logic             w_count_end;
    logic             w_abort;
    logic             w_count_en;

`ifdef NEURON_CTRL_ABORT_EN
    // Abort only matters while an evaluation is in flight
    assign w_abort = i_abort &&
                     ((r_state == CLEAR) || (r_state == ACCUM) || (r_state == SETTLE));
`else
    assign w_abort = 1'b0;
`endif

    assign w_count_en  = (r_state == ACCUM);
    assign w_count_end = (w_count == c_last_idx);

    term_counter #(
        .IDX_W (IDX_W),
        .N     (N)
    ) u_term_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_abort),
        .i_en    (w_count_en),
        .o_count (w_count),
        .o_last  (w_last)
    );

    // Sequencer state and all registered handshake/datapath controls
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_ld        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_abort) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_acc_clr <= 1'b0;
            r_ld      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_acc_clr <= 1'b0;
                    r_ld      <= 1'b0;
                    if (i_start) begin
                        r_state   <= CLEAR;
                        r_busy    <= 1'b1;
                        r_acc_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_acc_clr <= 1'b0;
                    r_ld      <= 1'b1;
                    r_state   <= ACCUM;
                end
                ACCUM: begin
                    if (w_count_end) begin
                        r_ld    <= 1'b0;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    // The last term has been accumulated, so the activated
                    // result from the datapath is stable this cycle.
                    if (w_last) begin
                        r_out_data  <= i_result_in;
                        r_out_valid <= 1'b1;
                        r_state     <= VALID;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                VALID: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        // The handshake edge doubles as the IDLE sampling
                        // point for start, giving an N+3 cycle period when
                        // start and out_ready are both held high.
                        if (i_start) begin
                            r_state   <= CLEAR;
                            r_acc_clr <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_acc_clr   <= 1'b0;
                    r_ld        <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_acc_clr   = r_acc_clr;
    assign o_ld        = r_ld;
    assign o_index     = w_count;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

endmodule : neuron_controller

`default_nettype wire

// File: tb/tb_neuron_controller.sv
// ============================================================================
// Module      : tb_neuron_controller
// Description : Self-checking bench for neuron_controller with N=4. A small
//               datapath model accumulates (index+1) per ld cycle and adds a
//               per-evaluation seed, so every full evaluation yields seed+10.
//               Exercises abort when NEURON_CTRL_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neuron_controller;

    localparam int N     = 4;
    localparam int IDX_W = 16;
    localparam int RES_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             out_ready = 1'b0;
`ifdef NEURON_CTRL_ABORT_EN
    logic             abort = 1'b0;
`endif
    logic             busy;
    logic             acc_clr;
    logic             ld;
    logic [IDX_W-1:0] index;
    logic [RES_W-1:0] result_in;
    logic             out_valid;
    logic [RES_W-1:0] out_data;

    logic [15:0] dp_seed = 16'h0000;
    logic [15:0] dp_acc;

    int          n_err = 0;
    int          n_chk = 0;
    logic [15:0] sb[$];

    typedef struct {
        logic [15:0] seed;
        int          hold;
        logic [15:0] exp_data;
    } vec_t;
    vec_t vecs[4];

    neuron_controller #(
        .N     (N),
        .IDX_W (IDX_W),
        .RES_W (RES_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
`ifdef NEURON_CTRL_ABORT_EN
        .i_abort     (abort),
`endif
        .o_busy      (busy),
        .o_acc_clr   (acc_clr),
        .o_ld        (ld),
        .o_index     (index),
        .i_result_in (result_in),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Datapath model: accumulator clears on acc_clr, adds index+1 on ld
    always @(posedge clk) begin
        if (!rst)         dp_acc <= 16'h0000;
        else if (acc_clr) dp_acc <= 16'h0000;
        else if (ld)      dp_acc <= dp_acc + index + 16'd1;
    end
    assign result_in = dp_seed + dp_acc;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Follow an evaluation whose start is sampled at the next rising edge
    task automatic follow_eval(input int hold);
        int          clr_cnt;
        int          ld_cnt;
        int          clr_at;
        int          valid_at;
        int          bad_idx;
        logic [15:0] held;
        clr_cnt  = 0;
        ld_cnt   = 0;
        clr_at   = -1;
        valid_at = -1;
        bad_idx  = 0;
        for (int c = 0; c < 40 && valid_at < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (acc_clr) begin
                clr_cnt++;
                if (clr_at < 0) clr_at = c;
            end
            if (ld) begin
                if (index != 16'(ld_cnt)) bad_idx++;
                ld_cnt++;
            end else if (index != 16'd0) begin
                bad_idx++;
            end
            if (out_valid) valid_at = c;
        end
        check("clear_next_edge", clr_at, 0);
        check("acc_clr_pulses", clr_cnt, 1);
        check("ld_cycles", ld_cnt, N);
        check("index_sequence", bad_idx, 0);
        check("valid_latency", valid_at - clr_at, N + 2);
        held = out_data;
        for (int h = 0; h < hold; h++) begin
            start = h[0];
            @(negedge clk);
            check("bp_valid_held", out_valid, 1);
            check("bp_data_held", out_data, held);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (sb.size() == 0) check("sb_has_entry", 0, 1);
        else                check("out_data", out_data, sb.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("idle_after_hs", busy, 0);
    endtask

    task automatic launch(input logic [15:0] seed, input logic [15:0] exp);
        @(negedge clk);
        dp_seed = seed;
        start   = 1'b1;
        sb.push_back(exp);
    endtask

    initial begin
        int last_clr;
        int bad_period;
        int over;
        int nclr;
        int found;
        int seen_valid;
        int drained;

        vecs[0] = '{seed: 16'h0119, hold: 0, exp_data: 16'h0123};
        vecs[1] = '{seed: 16'hA5A0, hold: 5, exp_data: 16'hA5AA};
        vecs[2] = '{seed: 16'hFFFF, hold: 2, exp_data: 16'h0009};
        vecs[3] = '{seed: 16'h7FF8, hold: 1, exp_data: 16'h8002};

        // Reset held with start high
        rst   = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_acc_clr", acc_clr, 0);
        check("rst_ld", ld, 0);
        check("rst_index", index, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);

        // Release: start still high, CLEAR entered on the next edge
        rst     = 1'b1;
        dp_seed = vecs[0].seed;
        sb.push_back(vecs[0].exp_data);
        follow_eval(vecs[0].hold);

        // Table of evaluations, including backpressure
        for (int i = 1; i < 4; i++) begin
            launch(vecs[i].seed, vecs[i].exp_data);
            follow_eval(vecs[i].hold);
        end

        // Back-to-back with start and out_ready held high
        @(negedge clk);
        dp_seed   = 16'h1000;
        start     = 1'b1;
        out_ready = 1'b1;
        last_clr   = -1;
        bad_period = 0;
        over       = 0;
        nclr       = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (acc_clr) begin
                if (last_clr >= 0 && (c - last_clr) != N + 3) bad_period++;
                last_clr = c;
                nclr++;
                sb.push_back(16'h100A);
            end
            if (index >= 16'(N)) over++;
            if (out_valid) begin
                if (sb.size() == 0) check("b2b_sb_has_entry", 0, 1);
                else                check("b2b_out_data", out_data, sb.pop_front());
            end
        end
        start   = 1'b0;
        drained = 0;
        for (int c = 0; c < 20 && drained == 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) check("b2b_sb_has_entry", 0, 1);
                else                check("b2b_out_data", out_data, sb.pop_front());
            end
            if (!busy && !out_valid) drained = 1;
        end
        out_ready = 1'b0;
        check("b2b_period", bad_period, 0);
        check("b2b_eval_count", nclr, 6);
        check("b2b_index_max", over, 0);
        check("b2b_drained", drained, 1);
        check("b2b_sb_empty", sb.size(), 0);

        // Reset in the middle of ACCUM at index 2
        @(negedge clk);
        dp_seed = 16'h0000;
        start   = 1'b1;
        found   = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (ld && index == 16'd2) found = 1;
        end
        check("mid_rst_reached_idx2", found, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_ld", ld, 0);
        check("mid_rst_index", index, 0);
        check("mid_rst_busy", busy, 0);
        seen_valid = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check("mid_rst_no_valid", seen_valid, 0);

`ifdef NEURON_CTRL_ABORT_EN
        // Abort at index 1, then a normal evaluation
        @(negedge clk);
        start = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (ld && index == 16'd1) found = 1;
        end
        check("abort_reached_idx1", found, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ld", ld, 0);
        check("abort_index", index, 0);
        check("abort_busy", busy, 0);
        seen_valid = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check("abort_no_valid", seen_valid, 0);
        launch(16'h0200, 16'h020A);
        follow_eval(0);
`endif

        check("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_neuron_controller

`default_nettype wire
